// File: rtl/cdc_bus_tx_pacer.sv
// Source-side pacer for the pulse/data CDC bus: buffers upstream words in a
// small FIFO and emits them as single-cycle strobes spaced by a programmable gap.
module cdc_bus_tx_pacer #(
  parameter int pDATA_WIDTH  = 8,
  parameter int pDEPTH       = 8,
  parameter int pGAP_WIDTH   = 8,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [pDATA_WIDTH-1:0]    in_data,
  input  logic [pGAP_WIDTH-1:0]     gap,
  output logic                      cdc_pulse,
  output logic [pDATA_WIDTH-1:0]    cdc_data,
  input  logic                      cdc_overflow,
  input  logic                      clear_error,
  output logic                      error,
  output logic [$clog2(pDEPTH):0]   fifo_level,
  output logic [pCOUNT_WIDTH-1:0]   sent_count
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(pDEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [pGAP_WIDTH-1:0]    cnt_q, cnt_d;
  logic [pGAP_WIDTH-1:0]    gap_eff;
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]              level_q, level_d;
  logic                     pulse_q;
  logic [pDATA_WIDTH-1:0]   data_q;
  logic [pCOUNT_WIDTH-1:0]  sent_q;
  logic                     error_q;
  logic                     do_push, do_pop;

  logic [pDATA_WIDTH-1:0]   mem_q [pDEPTH];

  assign in_ready   = (level_q != FULL_LEVEL) & ~reset_i;
  assign do_push    = in_valid & in_ready;
  assign gap_eff    = (gap == '0) ? pGAP_WIDTH'(1) : gap;

  assign cdc_pulse  = pulse_q;
  assign cdc_data   = data_q;
  assign error      = error_q;
  assign fifo_level = level_q;
  assign sent_count = sent_q;

  // In HOLD the counter expires at zero; a non-empty FIFO then re-strobes
  // directly so back-to-back spacing is max(gap,1)+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_pop  = 1'b0;
    if (state_q == IDLE) begin
      if (level_q != '0) begin
        do_pop  = 1'b1;
        state_d = HOLD;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (level_q != '0) begin
        do_pop = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
    if (do_pop) begin
      cnt_d = gap_eff;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pulse_q  <= 1'b0;
      data_q   <= '0;
      sent_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= do_pop;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
        sent_q   <= sent_q + 1'b1;
      end
      if (cdc_overflow) begin
        error_q <= 1'b1;
      end else if (clear_error) begin
        error_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdc_bus_tx_pacer.sv
// Scoreboard bench: accepted words and their acceptance edges are queued; the
// monitor predicts each strobe's edge from the gap rule and checks data/order.
module tb_cdc_bus_tx_pacer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [7:0]  gap = 8'd3;
  logic        cdc_pulse;
  logic [7:0]  cdc_data;
  logic        cdc_overflow = 1'b0;
  logic        clear_error = 1'b0;
  logic        error;
  logic [3:0]  fifo_level;
  logic [15:0] sent_count;

  cdc_bus_tx_pacer dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .gap          (gap),
    .cdc_pulse    (cdc_pulse),
    .cdc_data     (cdc_data),
    .cdc_overflow (cdc_overflow),
    .clear_error  (clear_error),
    .error        (error),
    .fifo_level   (fifo_level),
    .sent_count   (sent_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [7:0] d;
    int         e;
  } ent_t;

  ent_t        q[$];
  bit          rst_pend = 1'b1;
  bit          has_last = 1'b0;
  int          last_edge = 0;
  int          last_g = 1;
  int          g_prev = 1;
  logic [15:0] sent_m = '0;
  bit          err_m = 1'b0;
  bit          saw_full = 1'b0;

  function automatic int head_edge(input ent_t e);
    int t;
    t = e.e + 1;
    if (has_last && (last_edge + last_g + 1) > t) t = last_edge + last_g + 1;
    return t;
  endfunction

  always @(negedge clk) begin
    ent_t e;
    int   x;
    if (rst_pend) begin
      q.delete();
      sent_m   = '0;
      err_m    = 1'b0;
      has_last = 1'b0;
      rst_pend = 1'b0;
      check(cdc_data == 8'h00, "reset_data", cdc_data, 0);
    end
    check(error == err_m, "error", error, err_m);
    if (cdc_pulse) begin
      if (q.size() == 0) begin
        check(1'b0, "pulse_unexpected", cdc_data, 0);
      end else begin
        e = q.pop_front();
        x = head_edge(e);
        check(cyc == x, "pulse_edge", cyc, x);
        check(cdc_data == e.d, "pulse_data", cdc_data, e.d);
        $display("pulse edge=%0d data=%02h", cyc, cdc_data);
        sent_m++;
        has_last  = 1'b1;
        last_edge = cyc;
        last_g    = (g_prev == 0) ? 1 : g_prev;
      end
    end else if (q.size() > 0) begin
      x = head_edge(q[0]);
      check(cyc < x, "pulse_missing", cyc, x);
    end
    check(sent_count == sent_m, "sent_count", sent_count, sent_m);
    check(fifo_level == q.size(), "fifo_level", fifo_level, q.size());
    check(in_ready == ((q.size() != 8) && !reset_i), "in_ready", in_ready,
          (q.size() != 8) && !reset_i);
    if (q.size() == 8) saw_full = 1'b1;
    // effects of the inputs that the next rising edge will sample
    if (in_valid && in_ready) q.push_back('{d: in_data, e: cyc + 1});
    if (cdc_overflow) err_m = 1'b1;
    else if (clear_error) err_m = 1'b0;
    g_prev = int'(gap);
    if (reset_i) rst_pend = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 2000);
    if (!acc) check(1'b0, "send_timeout", n, 2000);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    bit acc;
    idle(3);
    reset_i = 1'b0;
    idle(2);

    // single word
    gap = 8'd3;
    send(8'hA5);
    idle(10);

    // burst spacing
    gap = 8'd5;
    for (int i = 1; i <= 8; i++) send(8'(i));
    idle(60);

    // backpressure
    gap = 8'd20;
    for (int i = 0; i < 12; i++) send(8'(8'h10 + i));
    idle(280);
    check(saw_full, "reached_full", saw_full, 1);

    // gap = 0
    gap = 8'd0;
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
    idle(15);

    // sticky error
    cdc_overflow = 1'b1; tick();
    cdc_overflow = 1'b0; tick();
    cdc_overflow = 1'b1; clear_error = 1'b1; tick();
    cdc_overflow = 1'b0; clear_error = 1'b0; tick();
    clear_error = 1'b1; tick();
    clear_error = 1'b0; idle(2);

    // reset mid-burst
    gap = 8'd10;
    for (int i = 0; i < 6; i++) send(8'(8'h60 + i));
    n = 0;
    while (sent_count < 16'd2 && n < 200) begin tick(); n++; end
    check(n < 200, "wait_two_sent", n, 200);
    reset_i = 1'b1; tick();
    reset_i = 1'b0; idle(40);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) gap = 8'($urandom_range(0, 6));
      cdc_overflow = ($urandom_range(0, 29) == 0);
      clear_error  = ($urandom_range(0, 9) == 0);
      reset_i      = ($urandom_range(0, 249) == 0);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; cdc_overflow = 1'b0; clear_error = 1'b0; reset_i = 1'b0;
    idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
